dacio_tx: RTL and testbench



---
 rtl/dacio_pkg.sv | 32 +++
 rtl/dacio_sfifo.sv | 52 +++++
 rtl/dacio_tx.sv | 162 ++++++++++++++++
 tb/tb_dacio_tx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dacio_pkg.sv
// dacio_pkg: shared types and helpers for the dacio_tx DDR lane driver.
// States, training words, idle code and the lane-split mapping.
package dacio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [15:0] TRAIN_A = 16'hAAAA;
  localparam logic [15:0] TRAIN_B = 16'h5555;
  localparam logic [15:0] IDLE_CODE_DEF = 16'h0000;

  typedef struct packed {
    logic [7:0] h;
    logic [7:0] l;
  } lanes_t;

  // odd bits ride the rising phase, even bits the falling phase
  function automatic lanes_t lane_split(
    input logic [15:0] w
  );
    lanes_t r;
    for (int k = 0; k < 8; k++) begin
      r.h[k] = w[2*k+1];
      r.l[k] = w[2*k];
    end
    return r;
  endfunction

endpackage

// File: rtl/dacio_sfifo.sv
// dacio_sfifo: synchronous sample FIFO with flush.
// Pointers carry one extra wrap bit to tell full from empty.
module dacio_sfifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [15:0]   din,
  output logic [15:0]   dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [15:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  assign full = (wptr[AW] != rptr[AW]) &&
                (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign level = wptr - rptr;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign dout = mem[rptr[AW-1:0]];

  // pointer update; flush empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dacio_tx.sv
// dacio_tx: LVDS DDR transmit lane driver (train, then stream).
// Optional ramp test pattern: define DACIO_TX_RAMP_EN.
module dacio_tx
  import dacio_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter int          TRAIN_LEN = 64,
  parameter logic [15:0] IDLE_CODE = IDLE_CODE_DEF
) (
  input  logic          clkin_sys,
  input  logic          io_reset_n,
  input  logic          tx_en,
  input  logic [15:0]   s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          clr_err,
  input  logic          tp_sel,
  output logic [7:0]    o_dout_h,
  output logic [7:0]    o_dout_l,
  output logic          o_oe,
  output logic          o_train_busy,
  output logic          o_underflow,
  output logic [AW:0]   o_fifo_level
);

  localparam int CW =
    (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          full, empty;
  logic          push, pop;
  logic          uf_set, ramp_on;
  logic [15:0]   head, ramp_word;
  logic [15:0]   word_nx, s1_word;
  logic          oe_nx, busy_nx;
  logic          s1_oe, s1_busy;

  assign s_ready = (state != IDLE) && !full;
  assign push = s_valid && s_ready;

  dacio_sfifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clkin_sys),
    .rst_n (io_reset_n),
    .flush (!tx_en),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (o_fifo_level)
  );

`ifdef DACIO_TX_RAMP_EN
  logic [15:0] ramp;
  assign ramp_on = (state == STREAM) && tp_sel;
  assign ramp_word = ramp;

  // ramp restarts from 0 on every STREAM entry
  always_ff @(posedge clkin_sys or negedge io_reset_n) begin
    if (!io_reset_n) ramp <= '0;
    else if (state == STREAM) ramp <= ramp + 16'd1;
    else ramp <= '0;
  end
`else
  logic unused_tp;
  assign unused_tp = tp_sel;
  assign ramp_on = 1'b0;
  assign ramp_word = IDLE_CODE;
`endif

  // next state, word selection, pop and underflow
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    word_nx = IDLE_CODE;
    oe_nx = 1'b0;
    busy_nx = 1'b0;
    pop = 1'b0;
    uf_set = 1'b0;
    if (!tx_en) begin
      state_nx = IDLE;
      cnt_nx = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nx = '0;
          state_nx = (TRAIN_LEN == 0) ? STREAM : TRAIN;
        end
        TRAIN: begin
          oe_nx = 1'b1;
          busy_nx = 1'b1;
          word_nx = cnt[0] ? TRAIN_B : TRAIN_A;
          cnt_nx = cnt + CW'(1);
          if (int'(cnt) == TRAIN_LEN - 1)
            state_nx = STREAM;
        end
        STREAM: begin
          oe_nx = 1'b1;
          if (ramp_on) begin
            word_nx = ramp_word;
          end else if (!empty) begin
            pop = 1'b1;
            word_nx = head;
          end else begin
            uf_set = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // state and training counter
  always_ff @(posedge clkin_sys or negedge io_reset_n) begin
    if (!io_reset_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end

  // two-stage output path; disable bypasses it
  always_ff @(posedge clkin_sys or negedge io_reset_n) begin
    if (!io_reset_n) begin
      s1_word <= IDLE_CODE;
      s1_oe <= 1'b0;
      s1_busy <= 1'b0;
      {o_dout_h, o_dout_l} <= lane_split(IDLE_CODE);
      o_oe <= 1'b0;
      o_train_busy <= 1'b0;
    end else if (!tx_en) begin
      s1_word <= IDLE_CODE;
      s1_oe <= 1'b0;
      s1_busy <= 1'b0;
      {o_dout_h, o_dout_l} <= lane_split(IDLE_CODE);
      o_oe <= 1'b0;
      o_train_busy <= 1'b0;
    end else begin
      s1_word <= word_nx;
      s1_oe <= oe_nx;
      s1_busy <= busy_nx;
      {o_dout_h, o_dout_l} <= lane_split(s1_word);
      o_oe <= s1_oe;
      o_train_busy <= s1_busy;
    end
  end

  // sticky underflow; a new underflow beats clr_err
  always_ff @(posedge clkin_sys or negedge io_reset_n) begin
    if (!io_reset_n) o_underflow <= 1'b0;
    else o_underflow <= uf_set | (o_underflow & ~clr_err);
  end

endmodule

// File: tb/tb_dacio_tx.sv
// tb_dacio_tx: randomized bench for dacio_tx against a queue model.
// Two instances: short training (4) and long training (24).
module tb_dacio_tx;

  localparam int NI    = 2;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [15:0] IDLEW = 16'h0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en = 1'b0;
  logic [15:0] s_data = '0;
  logic s_valid = 1'b0;
  logic clr_err = 1'b0;
  logic tp_sel = 1'b0;

  logic [NI-1:0]        rdy;
  logic [NI-1:0][7:0]   dh;
  logic [NI-1:0][7:0]   dl;
  logic [NI-1:0]        oe;
  logic [NI-1:0]        busy;
  logic [NI-1:0]        uf;
  logic [NI-1:0][AW:0]  lvl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dacio_tx #(
      .DEPTH     (DEPTH),
      .AW        (AW),
      .TRAIN_LEN (g == 0 ? 4 : 24),
      .IDLE_CODE (IDLEW)
    ) u_dut (
      .clkin_sys    (clk),
      .io_reset_n   (rst_n),
      .tx_en        (tx_en),
      .s_data       (s_data),
      .s_valid      (s_valid),
      .s_ready      (rdy[g]),
      .clr_err      (clr_err),
      .tp_sel       (tp_sel),
      .o_dout_h     (dh[g]),
      .o_dout_l     (dl[g]),
      .o_oe         (oe[g]),
      .o_train_busy (busy[g]),
      .o_underflow  (uf[g]),
      .o_fifo_level (lvl[g])
    );
  end

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] split_ref(
    input logic [15:0] w
  );
    logic [7:0] h;
    logic [7:0] l;
    for (int k = 0; k < 8; k++) begin
      h[k] = w[2*k+1];
      l[k] = w[2*k];
    end
    return {h, l};
  endfunction

  function automatic int tlen(input int i);
    return (i == 0) ? 4 : 24;
  endfunction

  // reference model: link phase, circular queue, output pipe
  bit          on_m  [NI];
  int          tleft [NI];
  int          tidx  [NI];
  logic [15:0] fm    [NI][DEPTH];
  int          fh    [NI];
  int          fc    [NI];
  logic [15:0] w1    [NI];
  bit          oe1   [NI];
  bit          b1    [NI];
  logic [15:0] ew    [NI];
  bit          eoe   [NI];
  bit          eb    [NI];
  bit          euf   [NI];
  logic [15:0] rmp   [NI];

  task automatic mreset();
    for (int i = 0; i < NI; i++) begin
      on_m[i] = 0; tleft[i] = 0; tidx[i] = 0;
      fh[i] = 0; fc[i] = 0;
      w1[i] = IDLEW; oe1[i] = 0; b1[i] = 0;
      ew[i] = IDLEW; eoe[i] = 0; eb[i] = 0;
      euf[i] = 0; rmp[i] = '0;
    end
  endtask

  task automatic mstep(input int i);
    bit rd, ufs, rm;
    rd = on_m[i] && (fc[i] < DEPTH);
    ufs = 0;
`ifdef DACIO_TX_RAMP_EN
    rm = tp_sel;
`else
    rm = 0;
`endif
    if (!tx_en) begin
      on_m[i] = 0; fh[i] = 0; fc[i] = 0;
      w1[i] = IDLEW; oe1[i] = 0; b1[i] = 0;
      ew[i] = IDLEW; eoe[i] = 0; eb[i] = 0;
      euf[i] = euf[i] & ~clr_err;
      rmp[i] = '0;
    end else begin
      ew[i] = w1[i]; eoe[i] = oe1[i]; eb[i] = b1[i];
      if (!on_m[i]) begin
        w1[i] = IDLEW; oe1[i] = 0; b1[i] = 0;
        on_m[i] = 1; tleft[i] = tlen(i); tidx[i] = 0;
        rmp[i] = '0;
      end else if (tleft[i] > 0) begin
        w1[i] = (tidx[i] % 2 == 0) ? 16'hAAAA : 16'h5555;
        oe1[i] = 1; b1[i] = 1;
        tidx[i]++; tleft[i]--;
        rmp[i] = '0;
      end else begin
        oe1[i] = 1; b1[i] = 0;
        if (rm) begin
          w1[i] = rmp[i];
        end else if (fc[i] > 0) begin
          w1[i] = fm[i][fh[i]];
          fh[i] = (fh[i] + 1) % DEPTH;
          fc[i]--;
        end else begin
          w1[i] = IDLEW;
          ufs = 1;
        end
        rmp[i] = rmp[i] + 16'd1;
      end
      euf[i] = ufs | (euf[i] & ~clr_err);
      if (rd && s_valid) begin
        fm[i][(fh[i] + fc[i]) % DEPTH] = s_data;
        fc[i]++;
      end
    end
  endtask

  initial mreset();

  // model advances on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else for (int i = 0; i < NI; i++) mstep(i);
  end

  // compare every output away from the active edge
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [15:0] sp;
      sp = split_ref(ew[i]);
      check($sformatf("u%0d.dout_h", i), 32'(dh[i]), 32'(sp[15:8]));
      check($sformatf("u%0d.dout_l", i), 32'(dl[i]), 32'(sp[7:0]));
      check($sformatf("u%0d.oe", i), 32'(oe[i]), 32'(eoe[i]));
      check($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(eb[i]));
      check($sformatf("u%0d.uf", i), 32'(uf[i]), 32'(euf[i]));
      check($sformatf("u%0d.level", i), 32'(lvl[i]), 32'(fc[i]));
      check($sformatf("u%0d.ready", i), 32'(rdy[i]),
            32'(on_m[i] && fc[i] < DEPTH));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int i, input string tag);
    check({tag, ".h"}, 32'(dh[i]), 32'h00);
    check({tag, ".l"}, 32'(dl[i]), 32'h00);
    check({tag, ".oe"}, 32'(oe[i]), 32'h0);
    check({tag, ".lvl"}, 32'(lvl[i]), 32'h0);
    check({tag, ".rdy"}, 32'(rdy[i]), 32'h0);
  endtask

  initial begin
    int k;
    bit r;
    bit seen_full;

    repeat (3) cyc();
    for (int i = 0; i < NI; i++) begin
      chk_idle(i, $sformatf("rst%0d", i));
      check($sformatf("rst%0d.busy", i), 32'(busy[i]), 0);
      check($sformatf("rst%0d.uf", i), 32'(uf[i]), 0);
    end
    rst_n = 1'b1;
    cyc();

    tx_en = 1'b1;
    cyc();
    cyc();
    for (int t = 0; t < 4; t++) begin
      cyc();
      check("train.h", 32'(dh[0]), (t % 2 == 0) ? 32'hFF : 32'h00);
      check("train.l", 32'(dl[0]), (t % 2 == 0) ? 32'h00 : 32'hFF);
      check("train.busy", 32'(busy[0]), 1);
    end
    cyc();
    check("post_train.busy", 32'(busy[0]), 0);
    check("post_train.oe", 32'(oe[0]), 1);

    s_valid = 1'b1;
    s_data = 16'h8001;
    cyc();
    s_valid = 1'b0;
    cyc();
    cyc();
    check("w8001.h", 32'(dh[0]), 32'h80);
    check("w8001.l", 32'(dl[0]), 32'h01);

    clr_err = 1'b1;
    cyc();
    check("uf_set_wins", 32'(uf[0]), 1);
    clr_err = 1'b0;
    s_valid = 1'b1;
    s_data = 16'h1234;
    cyc();
    cyc();
    clr_err = 1'b1;
    cyc();
    check("uf_cleared", 32'(uf[0]), 0);
    clr_err = 1'b0;
    s_valid = 1'b0;

    tx_en = 1'b0;
    cyc();
    tx_en = 1'b1;
    cyc();
    k = 0;
    seen_full = 0;
    for (int n = 0; n < 200 && k < 20; n++) begin
      s_valid = 1'b1;
      s_data = 16'h1000 + 16'(k);
      r = rdy[1];
      if (lvl[1] == 5'(DEPTH) && !rdy[1]) seen_full = 1;
      cyc();
      if (r) k++;
    end
    s_valid = 1'b0;
    check("burst.count", 32'(k), 20);
    check("burst.full_seen", 32'(seen_full), 1);
    repeat (40) cyc();
    check("burst.drained", 32'(lvl[1]), 0);

    tx_en = 1'b0;
    cyc();
    tx_en = 1'b1;
    cyc();
    s_valid = 1'b1;
    for (int n = 0; n < 7; n++) begin
      s_data = 16'(n * 16'h0101);
      cyc();
    end
    s_valid = 1'b0;
    check("pre_drop.lvl", 32'(lvl[1]), 7);
    tx_en = 1'b0;
    cyc();
    chk_idle(1, "drop");
    tx_en = 1'b1;

`ifdef DACIO_TX_RAMP_EN
    repeat (8) cyc();
    tp_sel = 1'b1;
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    repeat (20) cyc();
    check("ramp.uf", 32'(uf[0]), 0);
    check("ramp.lvl", 32'(lvl[0]), 0);
    tp_sel = 1'b0;
`endif

    for (int n = 0; n < 3000; n++) begin
      tx_en = ($urandom_range(0, 99) > 2);
      s_valid = 1'($urandom_range(0, 1));
      s_data = 16'($urandom);
      clr_err = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) tp_sel = ~tp_sel;
      if (n == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
          chk_idle(i, $sformatf("arst%0d", i));
          check($sformatf("arst%0d.uf", i), 32'(uf[i]), 0);
          check($sformatf("arst%0d.busy", i), 32'(busy[i]), 0);
        end
        cyc();
        rst_n = 1'b1;
      end
      cyc();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
